// File: rtl/hs_reader.sv
// Consumer side of the writer's four-phase req/ack handshake. Captured words go
// through a small FIFO and leave on a valid/ready port; a wrapping counter tallies captures.
module hs_reader #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    q,
  input  logic          req,
  output logic          ack,
  output logic [7:0]    dout,
  output logic          dvalid,
  input  logic          dready,
  output logic [AW:0]   level,
  output logic [15:0]   count
);
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_CAPT, R_REL} state_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  state_t        r_state;
  logic          r_ack;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic [15:0]   r_count;

  logic w_push, w_pop, w_nempty;

  assign w_nempty = (r_level != '0);
  assign w_push   = (r_state == R_CAPT);
  assign w_pop    = w_nempty && dready;

  // Space is only checked before acking; one word in flight means the push never overflows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (req && (r_level < LVL_FULL)) begin
          r_state <= R_ACK;
          r_ack   <= 1'b1;
        end
        R_ACK:  r_state <= R_CAPT;
        R_CAPT: r_state <= R_REL;
        R_REL:  if (!req) begin
          r_state <= R_IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= R_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr  <= r_wptr + 1'b1;
        r_count <= r_count + 16'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= q;
  end

  assign ack    = r_ack;
  assign dvalid = w_nempty;
  assign dout   = w_nempty ? r_mem[r_rptr] : 8'h00;
  assign level  = r_level;
  assign count  = r_count;
endmodule

// File: tb/tb_hs_reader.sv
// Bench for hs_reader: cycle table for a single transfer, directed corner sequences,
// random traffic checked every cycle against a queue-based model of the handshake/FIFO.
module tb_hs_reader;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  q;
  logic        req;
  logic        ack;
  logic [7:0]  dout;
  logic        dvalid;
  logic        dready;
  logic [AW:0] level;
  logic [15:0] count;

  hs_reader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .q(q), .req(req), .ack(ack), .dout(dout),
    .dvalid(dvalid), .dready(dready), .level(level), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit rnd_sink = 1'b0;
  int cnt_base = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is captured at the edge ending the second consecutive ack=1 cycle.
  logic [7:0] mq[$];
  int mcount = 0;
  int run    = 0;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        mq.delete();
        mcount = 0;
        run    = 0;
      end
      chk("mon_dvalid", int'(dvalid), int'(mq.size() != 0));
      chk("mon_level",  int'(level),  mq.size());
      chk("mon_dout",   int'(dout),   (mq.size() != 0) ? int'(mq[0]) : 0);
      chk("mon_count",  int'(count),  (cnt_base + mcount) % 65536);
      if (!reset) begin
        run = ack ? run + 1 : 0;
        if (mq.size() != 0 && dready) void'(mq.pop_front());
        if (run == 2) begin
          mq.push_back(q);
          mcount = mcount + 1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_sink) dready = 1'($urandom_range(0, 1));
  endtask

  task automatic xfer(input logic [7:0] d, input bit chk_lat);
    int w;
    w = 0;
    tick();
    req = 1'b1;
    q   = 8'($urandom);
    do begin
      tick();
      w++;
    end while (!ack && w < 50);
    if (!ack) begin
      chk("xfer_ack_timeout", 0, 1);
      req = 1'b0;
      return;
    end
    if (chk_lat) chk("ack_latency", w, 1);
    q = d;
    tick();            // capture cycle
    tick();            // release cycle
    req = 1'b0;
    q   = 8'($urandom);
    tick();
    chk("ack_fall", int'(ack), 0);
  endtask

  typedef struct {
    logic       req;
    logic [7:0] q;
    logic       dr;
    logic       ack;
    logic       dv;
    logic [7:0] dout;
    int         lvl;
    int         cnt;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             req q      dr  ack dv dout   lvl cnt
    tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
    tbl[2] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1, 1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1, 1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 1, 1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1};

    // Asynchronous reset with random inputs, checked before any clock edge.
    reset  = 1'b0;
    req    = 1'($urandom);
    q      = 8'($urandom);
    dready = 1'($urandom);
    #2 reset = 1'b1;
    #1;
    chk("rst_ack",    int'(ack),    0);
    chk("rst_dvalid", int'(dvalid), 0);
    chk("rst_dout",   int'(dout),   0);
    chk("rst_level",  int'(level),  0);
    chk("rst_count",  int'(count),  0);
    repeat (3) tick();
    req = 1'b0; dready = 1'b0;
    reset = 1'b0;
    tick();

    // Single transfer of 8'h5A, cycle by cycle.
    foreach (tbl[i]) begin
      tick();
      req = tbl[i].req; q = tbl[i].q; dready = tbl[i].dr;
      #1;
      chk($sformatf("tbl%0d_ack", i),  int'(ack),    int'(tbl[i].ack));
      chk($sformatf("tbl%0d_dv", i),   int'(dvalid), int'(tbl[i].dv));
      chk($sformatf("tbl%0d_dout", i), int'(dout),   int'(tbl[i].dout));
      chk($sformatf("tbl%0d_lvl", i),  int'(level),  tbl[i].lvl);
      chk($sformatf("tbl%0d_cnt", i),  int'(count),  tbl[i].cnt);
    end
    dready = 1'b0;

    // Backpressure: fill, stall the fifth request, release with one pop.
    for (int i = 1; i <= DEPTH; i++) xfer(8'(i), 1'b1);
    chk("bp_full_level", int'(level), DEPTH);
    tick();
    req = 1'b1; q = 8'h00;
    repeat (3) begin
      tick();
      chk("bp_hold_ack", int'(ack), 0);
    end
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("bp_pop_ack", int'(ack), 0);
    chk("bp_pop_level", int'(level), DEPTH - 1);
    tick();
    chk("bp_release_ack", int'(ack), 1);
    q = 8'h05;
    tick();
    tick();
    chk("bp_refill_level", int'(level), DEPTH);
    req = 1'b0;
    tick();
    chk("bp_ack_fall", int'(ack), 0);
    dready = 1'b1;
    repeat (DEPTH + 2) tick();
    dready = 1'b0;
    chk("bp_drain_level", int'(level), 0);

    // Push and pop on the same edge at level 2.
    xfer(8'hA1, 1'b1);
    xfer(8'hA2, 1'b1);
    tick();
    req = 1'b1;
    tick();
    chk("pp_ack", int'(ack), 1);
    q = 8'hB3;
    tick();
    dready = 1'b1;
    chk("pp_level_before", int'(level), 2);
    tick();
    dready = 1'b0;
    chk("pp_level_after", int'(level), 2);
    req = 1'b0;
    tick();
    dready = 1'b1;
    repeat (4) tick();
    dready = 1'b0;

    // Random traffic with random gaps and sink stalls; order checked by the model across wraps.
    rnd_sink = 1'b1;
    for (int i = 0; i < 6 * DEPTH; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      xfer(8'($urandom), 1'b0);
    end
    rnd_sink = 1'b0;
    dready = 1'b1;
    repeat (DEPTH + 4) tick();
    chk("rnd_drain_level", int'(level), 0);

    // Counter wrap: preset near the top instead of 65k real transfers.
    tick();
    force dut.r_count = 16'hFFFE;
    cnt_base = (65534 - mcount) & 16'hFFFF;
    tick();
    release dut.r_count;
    xfer(8'hE1, 1'b1);
    chk("wrap_ffff", int'(count), 16'hFFFF);
    xfer(8'hE2, 1'b1);
    chk("wrap_zero", int'(count), 0);
    xfer(8'hE3, 1'b1);
    tick();
    chk("wrap_one", int'(count), 1);
    chk("wrap_level", int'(level), 0);

    // Reset during the capture cycle drops the word immediately.
    dready = 1'b0;
    tick();
    req = 1'b1;
    tick();
    q = 8'hC7;
    tick();
    reset = 1'b1;
    cnt_base = 0;
    #2;
    chk("rc_ack",   int'(ack),    0);
    chk("rc_level", int'(level),  0);
    chk("rc_count", int'(count),  0);
    chk("rc_dv",    int'(dvalid), 0);
    tick();
    req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rc_no_word", int'(dvalid), 0);
    xfer(8'h3C, 1'b1);
    chk("rc_next_count", int'(count), 1);
    chk("rc_next_dout",  int'(dout),  16'h3C);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
